// File: rtl/stage_memory0.sv
// -----------------------------------------------------------------------------
// stage_memory0 -- first memory pipeline stage (execute -> stage_memory1)
//
// Registers the execute-stage memory/CSR operation, checks load/store
// alignment and arbitrates the single dcache TLB/CAM read port between:
//   P1  memory1 page-table-walk reads   (single-cycle pulse, always wins)
//   P2  fetch1 page-table-walk reads    (level request, may go pending)
//   P3  this stage's own load/store
// A dcache read issued in cycle N is seen by memory1 in cycle N+1, so
// memory1 registers everything presented on the mem0_* outputs.
//
// Ports
//   clk_core, reset_n         core clock, synchronous active-low reset
//   ex_*                      operation from execute (valid, exception,
//                             pc, read/write/extend/width, addr, wdata, rd)
//   mem0_stall                stall back to execute
//   fe1_mem0_read/_addr       fetch1 PTE read request and physical address
//   mem0_fe1_ack              fetch1 request issued this cycle
//   mem1_mem0_read/_addr      memory1 PTE read pulse and physical address
//   mem1_stall                memory1 stall
//   csr_kill_setpc            pipeline flush
//   mem0_tlb_read_req/_vpn    dcache TLB lookup
//   mem0_cam_read_req/_index  dcache CAM read
//   mem0_* (operation)        operation presented to memory1
//   mem0_mem1_req             port currently owned by a memory1 PTW read
//   mem0_fe1_req              operation presented is a fetch1 PTW read
//
// Handshake: the execute stage holds ex_* steady while mem0_stall is high;
// the stage register captures ex_* on every edge where mem0_stall is low.
// fetch1 holds its request until it sees mem0_fe1_ack; memory1 pulses its
// request for exactly one cycle.
// -----------------------------------------------------------------------------
module stage_memory0 (
    input  logic        clk_core,
    input  logic        reset_n,

    input  logic        ex_valid,
    output logic        mem0_stall,
    input  logic        ex_exc,
    input  logic [3:0]  ex_exc_cause,
    input  logic [31:2] ex_pc,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic        ex_extend,
    input  logic [1:0]  ex_width,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_wb_reg,

    input  logic        fe1_mem0_read,
    input  logic [28:2] fe1_mem0_addr,
    output logic        mem0_fe1_ack,

    input  logic        mem1_mem0_read,
    input  logic [28:2] mem1_mem0_addr,
    input  logic        mem1_stall,
    input  logic        csr_kill_setpc,

    output logic        mem0_tlb_read_req,
    output logic [31:12] mem0_tlb_read_vpn,
    output logic        mem0_cam_read_req,
    output logic [11:2] mem0_cam_read_index,

    output logic        mem0_valid,
    output logic        mem0_exc,
    output logic [3:0]  mem0_exc_cause,
    output logic [31:2] mem0_pc,
    output logic        mem0_read,
    output logic        mem0_write,
    output logic        mem0_extend,
    output logic [1:0]  mem0_width,
    output logic [31:0] mem0_addr,
    output logic [31:0] mem0_wdata,
    output logic [4:0]  mem0_wb_reg,
    output logic        mem0_mem1_req,
    output logic        mem0_fe1_req
);

    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        op_valid_q;
    logic        op_exc_q;
    logic [3:0]  op_exc_cause_q;
    logic [31:2] op_pc_q;
    logic        op_read_q;
    logic        op_write_q;
    logic        op_extend_q;
    logic [1:0]  op_width_q;
    logic [31:0] op_addr_q;
    logic [31:0] op_wdata_q;
    logic [4:0]  op_wb_reg_q;

    logic        fe1_pend_q, fe1_pend_d;
    logic [28:2] fe1_addr_q, fe1_addr_d;
    logic        hold1_q,    hold1_d;

    // ------------------------------------------------------------------
    // Alignment check on the registered operation. CSR ops (read&write)
    // and non-memory ops are never checked.
    // ------------------------------------------------------------------
    logic       op_is_dc;
    logic       op_misalign;
    logic       op_exc;
    logic [3:0] op_cause;

    assign op_is_dc    = op_read_q ^ op_write_q;
    assign op_misalign = op_is_dc &
                         (((op_width_q == 2'b01) & op_addr_q[0]) |
                          (op_width_q[1] & (op_addr_q[1:0] != 2'b00)));
    assign op_exc      = op_valid_q & (op_exc_q | op_misalign);
    // An upstream exception keeps its own cause.
    assign op_cause    = op_exc_q  ? op_exc_cause_q :
                         op_read_q ? CAUSE_LMISALIGN : CAUSE_SMISALIGN;

    // ------------------------------------------------------------------
    // Port arbitration
    // ------------------------------------------------------------------
    logic        fe1_want;
    logic [28:2] fe1_addr_eff;
    logic        gnt_p1, gnt_p2, gnt_p3;

    assign fe1_want     = fe1_mem0_read | fe1_pend_q;
    assign fe1_addr_eff = fe1_pend_q ? fe1_addr_q : fe1_mem0_addr;

    assign gnt_p1 = mem1_mem0_read;
    assign gnt_p2 = ~gnt_p1 & fe1_want & ~mem1_stall;
    assign gnt_p3 = ~gnt_p1 & ~gnt_p2 & op_valid_q & ~mem1_stall &
                    op_is_dc & ~op_exc;

    // The own op can only be blocked by memory1 stalling or by losing the
    // port; an excepting or non-dcache op advances without a read.
    assign mem0_stall = op_valid_q & (mem1_stall | gnt_p1 | gnt_p2);

    assign mem0_fe1_ack  = gnt_p2;
    assign mem0_fe1_req  = gnt_p2;
    // Keeps memory1's translation off through the cycle its PTE data returns
    // and for as long as it stays stalled (CAM-miss fill).
    assign mem0_mem1_req = mem1_mem0_read | hold1_q;

    // ------------------------------------------------------------------
    // dcache TLB/CAM port
    // ------------------------------------------------------------------
    always_comb begin
        mem0_cam_read_req   = gnt_p1 | gnt_p2 | gnt_p3;
        mem0_tlb_read_req   = gnt_p3;
        mem0_tlb_read_vpn   = '0;
        mem0_cam_read_index = '0;
        if (gnt_p1) begin
            mem0_cam_read_index = mem1_mem0_addr[11:2];
        end else if (gnt_p2) begin
            mem0_cam_read_index = fe1_addr_eff[11:2];
        end else if (gnt_p3) begin
            mem0_cam_read_index = op_addr_q[11:2];
            mem0_tlb_read_vpn   = op_addr_q[31:12];
        end
    end

    // ------------------------------------------------------------------
    // Operation presented to memory1
    // ------------------------------------------------------------------
    always_comb begin
        mem0_valid     = op_valid_q & ~gnt_p1;
        mem0_exc       = op_exc;
        mem0_exc_cause = op_exc ? op_cause : 4'd0;
        mem0_pc        = op_pc_q;
        mem0_read      = op_read_q;
        mem0_write     = op_write_q;
        mem0_extend    = op_extend_q;
        mem0_width     = op_width_q;
        mem0_addr      = op_addr_q;
        mem0_wdata     = op_wdata_q;
        mem0_wb_reg    = op_wb_reg_q;
        if (gnt_p2) begin
            // A fetch1 PTE read looks like a plain word load to memory1.
            mem0_valid     = 1'b1;
            mem0_exc       = 1'b0;
            mem0_exc_cause = 4'd0;
            mem0_pc        = '0;
            mem0_read      = 1'b1;
            mem0_write     = 1'b0;
            mem0_extend    = 1'b0;
            mem0_width     = 2'b10;
            mem0_addr      = {3'b000, fe1_addr_eff, 2'b00};
            mem0_wdata     = '0;
            mem0_wb_reg    = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pending fetch1 request and memory1 hold
    // ------------------------------------------------------------------
    always_comb begin
        fe1_pend_d = fe1_pend_q;
        fe1_addr_d = fe1_addr_q;
        if (csr_kill_setpc | gnt_p2) begin
            fe1_pend_d = 1'b0;
        end else if (fe1_mem0_read & ~fe1_pend_q) begin
            fe1_pend_d = 1'b1;
            fe1_addr_d = fe1_mem0_addr;
        end
        hold1_d = mem1_mem0_read | (hold1_q & mem1_stall);
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            op_valid_q     <= 1'b0;
            op_exc_q       <= 1'b0;
            op_exc_cause_q <= '0;
            op_pc_q        <= '0;
            op_read_q      <= 1'b0;
            op_write_q     <= 1'b0;
            op_extend_q    <= 1'b0;
            op_width_q     <= '0;
            op_addr_q      <= '0;
            op_wdata_q     <= '0;
            op_wb_reg_q    <= '0;
            fe1_pend_q     <= 1'b0;
            fe1_addr_q     <= '0;
            hold1_q        <= 1'b0;
        end else begin
            // Flush wins over a new load of the stage register.
            if (csr_kill_setpc) begin
                op_valid_q <= 1'b0;
            end else if (!mem0_stall) begin
                op_valid_q <= ex_valid;
            end
            if (!mem0_stall) begin
                op_exc_q       <= ex_exc;
                op_exc_cause_q <= ex_exc_cause;
                op_pc_q        <= ex_pc;
                op_read_q      <= ex_read;
                op_write_q     <= ex_write;
                op_extend_q    <= ex_extend;
                op_width_q     <= ex_width;
                op_addr_q      <= ex_addr;
                op_wdata_q     <= ex_wdata;
                op_wb_reg_q    <= ex_wb_reg;
            end
            fe1_pend_q <= fe1_pend_d;
            fe1_addr_q <= fe1_addr_d;
            hold1_q    <= hold1_d;
        end
    end

endmodule

// File: tb/tb_stage_memory0.sv
// -----------------------------------------------------------------------------
// tb_stage_memory0 -- self-checking bench for stage_memory0
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_stage_memory0;

    // ---------------- clock / reset ----------------
    logic clk_core = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clk_core = ~clk_core;

    // ---------------- DUT signals ----------------
    logic        ex_valid, ex_exc, ex_read, ex_write, ex_extend;
    logic [3:0]  ex_exc_cause;
    logic [31:2] ex_pc;
    logic [1:0]  ex_width;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_wb_reg;
    logic        fe1_mem0_read, mem1_mem0_read, mem1_stall, csr_kill_setpc;
    logic [28:2] fe1_mem0_addr, mem1_mem0_addr;

    logic        mem0_stall, mem0_fe1_ack, mem0_tlb_read_req, mem0_cam_read_req;
    logic [31:12] mem0_tlb_read_vpn;
    logic [11:2] mem0_cam_read_index;
    logic        mem0_valid, mem0_exc, mem0_read, mem0_write, mem0_extend;
    logic [3:0]  mem0_exc_cause;
    logic [31:2] mem0_pc;
    logic [1:0]  mem0_width;
    logic [31:0] mem0_addr, mem0_wdata;
    logic [4:0]  mem0_wb_reg;
    logic        mem0_mem1_req, mem0_fe1_req;

    stage_memory0 dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .ex_valid(ex_valid), .mem0_stall(mem0_stall), .ex_exc(ex_exc),
        .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc), .ex_read(ex_read),
        .ex_write(ex_write), .ex_extend(ex_extend), .ex_width(ex_width),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wb_reg(ex_wb_reg),
        .fe1_mem0_read(fe1_mem0_read), .fe1_mem0_addr(fe1_mem0_addr),
        .mem0_fe1_ack(mem0_fe1_ack), .mem1_mem0_read(mem1_mem0_read),
        .mem1_mem0_addr(mem1_mem0_addr), .mem1_stall(mem1_stall),
        .csr_kill_setpc(csr_kill_setpc),
        .mem0_tlb_read_req(mem0_tlb_read_req), .mem0_tlb_read_vpn(mem0_tlb_read_vpn),
        .mem0_cam_read_req(mem0_cam_read_req), .mem0_cam_read_index(mem0_cam_read_index),
        .mem0_valid(mem0_valid), .mem0_exc(mem0_exc), .mem0_exc_cause(mem0_exc_cause),
        .mem0_pc(mem0_pc), .mem0_read(mem0_read), .mem0_write(mem0_write),
        .mem0_extend(mem0_extend), .mem0_width(mem0_width), .mem0_addr(mem0_addr),
        .mem0_wdata(mem0_wdata), .mem0_wb_reg(mem0_wb_reg),
        .mem0_mem1_req(mem0_mem1_req), .mem0_fe1_req(mem0_fe1_req)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_core);
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_exc = 0; ex_exc_cause = 0; ex_pc = 0; ex_read = 0;
        ex_write = 0; ex_extend = 0; ex_width = 0; ex_addr = 0; ex_wdata = 0;
        ex_wb_reg = 0; fe1_mem0_read = 0; fe1_mem0_addr = 0; mem1_mem0_read = 0;
        mem1_mem0_addr = 0; mem1_stall = 0; csr_kill_setpc = 0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] w,
                            input logic [31:0] a, input logic xe, input logic [3:0] xc);
        ex_valid = 1; ex_read = rd; ex_write = wr; ex_width = w; ex_addr = a;
        ex_exc = xe; ex_exc_cause = xc; ex_pc = 30'h100; ex_wdata = 32'hCAFE0000;
        ex_wb_reg = 5'd7; ex_extend = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        rd, wr;
        logic [1:0]  w;
        logic [31:0] a;
        logic        xe;
        logic [3:0]  xc;
        logic        e_exc;
        logic [3:0]  e_cause;
        logic        e_cam, e_tlb;
        logic [9:0]  e_idx;
        logic [19:0] e_vpn;
    } vec_t;

    vec_t vecs[11];

    // ---------------- reference model state ----------------
    logic        m_valid, m_rd, m_wr, m_ext, m_exc;
    logic [1:0]  m_w;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_cause;
    logic [31:2] m_pc;
    logic [4:0]  m_wb;
    logic        m_pend, m_hold;
    logic [28:2] m_paddr;

    initial begin
        vecs[0]  = '{1,0,2'b10,32'h00001234,0,4'd0, 0,4'd0, 1,1,10'h08D,20'h00001};
        vecs[1]  = '{1,0,2'b01,32'h00001001,0,4'd0, 1,4'd4, 0,0,10'h000,20'h00000};
        vecs[2]  = '{0,1,2'b10,32'h00001002,0,4'd0, 1,4'd6, 0,0,10'h000,20'h00000};
        vecs[3]  = '{1,0,2'b01,32'h00001002,0,4'd0, 0,4'd0, 1,1,10'h000,20'h00001};
        vecs[4]  = '{1,0,2'b00,32'h00001003,0,4'd0, 0,4'd0, 1,1,10'h000,20'h00001};
        vecs[5]  = '{0,1,2'b01,32'h00002FFE,0,4'd0, 0,4'd0, 1,1,10'h3FF,20'h00002};
        vecs[6]  = '{1,0,2'b11,32'h00001006,0,4'd0, 1,4'd4, 0,0,10'h000,20'h00000};
        vecs[7]  = '{1,1,2'b10,32'h00000003,0,4'd0, 0,4'd0, 0,0,10'h000,20'h00000};
        vecs[8]  = '{1,0,2'b10,32'h00001001,1,4'd2, 1,4'd2, 0,0,10'h000,20'h00000};
        vecs[9]  = '{0,0,2'b01,32'h00001001,0,4'd0, 0,4'd0, 0,0,10'h000,20'h00000};
        vecs[10] = '{0,1,2'b10,32'hFFFFF008,0,4'd0, 0,4'd0, 1,1,10'h002,20'hFFFFF};

        // ---------- reset state ----------
        do_reset();
        mid();
        chk("rst_ctl", {mem0_stall, mem0_fe1_ack, mem0_tlb_read_req, mem0_cam_read_req,
                        mem0_valid, mem0_exc, mem0_mem1_req, mem0_fe1_req}, 0);
        tick();

        // ---------- table: alignment / index / vpn ----------
        for (int i = 0; i < 11; i++) begin
            drive_op(vecs[i].rd, vecs[i].wr, vecs[i].w, vecs[i].a, vecs[i].xe, vecs[i].xc);
            tick();
            drive_idle();
            mid();
            chk($sformatf("vec%0d_valid", i), mem0_valid, 1);
            chk($sformatf("vec%0d_stall", i), mem0_stall, 0);
            chk($sformatf("vec%0d_exc", i), mem0_exc, vecs[i].e_exc);
            chk($sformatf("vec%0d_cause", i), mem0_exc_cause, vecs[i].e_cause);
            chk($sformatf("vec%0d_cam", i), mem0_cam_read_req, vecs[i].e_cam);
            chk($sformatf("vec%0d_tlb", i), mem0_tlb_read_req, vecs[i].e_tlb);
            chk($sformatf("vec%0d_idx", i), mem0_cam_read_index, vecs[i].e_idx);
            chk($sformatf("vec%0d_vpn", i), mem0_tlb_read_vpn, vecs[i].e_vpn);
            tick();
        end

        // ---------- A: memory1 PTW read during memory1 stall ----------
        drive_op(1, 0, 2'b10, 32'h00003000, 0, 0);
        tick();
        drive_idle();
        mem1_stall = 1; mem1_mem0_read = 1; mem1_mem0_addr = 27'h0000100;
        mid();
        chk("A_cam", mem0_cam_read_req, 1);
        chk("A_idx", mem0_cam_read_index, 10'h100);
        chk("A_tlb", mem0_tlb_read_req, 0);
        chk("A_m1req", mem0_mem1_req, 1);
        chk("A_stall", mem0_stall, 1);
        tick();
        mem1_mem0_read = 0;
        mid();
        chk("A_hold_m1req", mem0_mem1_req, 1);
        chk("A_hold_cam", mem0_cam_read_req, 0);
        chk("A_hold_stall", mem0_stall, 1);
        tick();
        mem1_stall = 0;
        mid();
        chk("A_rel_tlb", mem0_tlb_read_req, 1);
        chk("A_rel_vpn", mem0_tlb_read_vpn, 20'h00003);
        chk("A_rel_stall", mem0_stall, 0);
        tick();
        mid();
        chk("A_done_m1req", mem0_mem1_req, 0);
        chk("A_done_valid", mem0_valid, 0);
        tick();

        // ---------- B: fetch1 request pends during stall ----------
        drive_op(0, 1, 2'b10, 32'h00004008, 0, 0);
        tick();
        drive_idle();
        mem1_stall = 1; fe1_mem0_read = 1; fe1_mem0_addr = 27'h0000040;
        mid();
        chk("B_ack_stalled", mem0_fe1_ack, 0);
        chk("B_stall", mem0_stall, 1);
        tick();
        fe1_mem0_read = 0;
        mid();
        chk("B_ack_pend", mem0_fe1_ack, 0);
        tick();
        mem1_stall = 0;
        mid();
        chk("B_ack", mem0_fe1_ack, 1);
        chk("B_fe1req", mem0_fe1_req, 1);
        chk("B_valid", mem0_valid, 1);
        chk("B_addr", mem0_addr, 32'h00000100);
        chk("B_rw", {mem0_read, mem0_write, mem0_width}, 4'b1010);
        chk("B_idx", mem0_cam_read_index, 10'h040);
        chk("B_tlb", mem0_tlb_read_req, 0);
        chk("B_stall_own", mem0_stall, 1);
        tick();
        mid();
        chk("B_own_ack", mem0_fe1_ack, 0);
        chk("B_own_tlb", mem0_tlb_read_req, 1);
        chk("B_own_idx", mem0_cam_read_index, 10'h002);
        chk("B_own_write", mem0_write, 1);
        tick();

        // ---------- C: P1 and fe1 in the same cycle ----------
        drive_op(1, 0, 2'b00, 32'h00005000, 0, 0);
        tick();
        drive_idle();
        mem1_mem0_read = 1; mem1_mem0_addr = 27'h00000AB;
        fe1_mem0_read = 1; fe1_mem0_addr = 27'h0000055;
        mid();
        chk("C_p1_idx", mem0_cam_read_index, 10'h0AB);
        chk("C_p1_ack", mem0_fe1_ack, 0);
        tick();
        mem1_mem0_read = 0;
        mid();
        chk("C_fe1_ack", mem0_fe1_ack, 1);
        chk("C_fe1_idx", mem0_cam_read_index, 10'h055);
        tick();
        fe1_mem0_read = 0;
        mid();
        chk("C_own_tlb", mem0_tlb_read_req, 1);
        tick();

        // ---------- D: flush clears op and pending fetch1 ----------
        drive_op(1, 0, 2'b10, 32'h00006000, 0, 0);
        tick();
        drive_idle();
        mem1_stall = 1; fe1_mem0_read = 1; fe1_mem0_addr = 27'h0000012;
        tick();
        fe1_mem0_read = 0; csr_kill_setpc = 1;
        tick();
        csr_kill_setpc = 0; mem1_stall = 0;
        mid();
        chk("D_valid", mem0_valid, 0);
        chk("D_ack", mem0_fe1_ack, 0);
        chk("D_cam", mem0_cam_read_req, 0);
        chk("D_stall", mem0_stall, 0);
        tick();

        // ---------- E: reset mid-operation ----------
        drive_op(1, 0, 2'b10, 32'h00007004, 0, 0);
        tick();
        drive_idle();
        mem1_stall = 1; mem1_mem0_read = 1; fe1_mem0_read = 1; fe1_mem0_addr = 27'h1;
        tick();
        drive_idle();
        reset_n = 0;
        tick();
        mid();
        chk("E_ctl", {mem0_stall, mem0_fe1_ack, mem0_tlb_read_req, mem0_cam_read_req,
                      mem0_valid, mem0_exc, mem0_mem1_req, mem0_fe1_req,
                      mem0_read, mem0_write, mem0_extend, mem0_width, mem0_exc_cause,
                      mem0_wb_reg}, 0);
        chk("E_pc", mem0_pc, 0);
        chk("E_addr", mem0_addr, 0);
        chk("E_wdata", mem0_wdata, 0);
        chk("E_ports", {mem0_tlb_read_vpn, mem0_cam_read_index}, 0);
        reset_n = 1;
        tick();

        // ---------- random phase against the reference model ----------
        do_reset();
        m_valid = 0; m_rd = 0; m_wr = 0; m_ext = 0; m_exc = 0; m_w = 0; m_addr = 0;
        m_wdata = 0; m_cause = 0; m_pc = 0; m_wb = 0; m_pend = 0; m_hold = 0; m_paddr = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            automatic int          win;
            automatic int          sz;
            automatic logic        want, is_dc, mis, op_exc, exp_stall, exp_valid, moves;
            automatic logic [28:2] faddr;
            automatic logic [31:0] exp_idx, exp_vpn, exp_addr;
            automatic logic [3:0]  exp_cause;

            // stimulus
            ex_valid = 1'($urandom_range(0, 1));
            {ex_read, ex_write} = 2'($urandom_range(0, 3));
            ex_width = 2'($urandom_range(0, 3));
            ex_addr = $urandom;
            ex_exc = ($urandom_range(0, 15) == 0);
            ex_exc_cause = 4'($urandom_range(0, 15));
            ex_pc = 30'($urandom);
            ex_wdata = $urandom;
            ex_wb_reg = 5'($urandom_range(0, 31));
            ex_extend = 1'($urandom_range(0, 1));
            mem1_stall = ($urandom_range(0, 2) == 0);
            mem1_mem0_read = ($urandom_range(0, 9) == 0);
            mem1_mem0_addr = 27'($urandom);
            csr_kill_setpc = ($urandom_range(0, 24) == 0);
            if (!fe1_mem0_read && $urandom_range(0, 5) == 0) begin
                fe1_mem0_read = 1;
                fe1_mem0_addr = 27'($urandom);
            end

            mid();
            // reference: who owns the port this cycle
            want  = fe1_mem0_read || m_pend;
            faddr = m_pend ? m_paddr : fe1_mem0_addr;
            is_dc = (m_rd != m_wr);
            sz    = (m_w == 2'b00) ? 1 : (m_w == 2'b01) ? 2 : 4;
            mis   = is_dc && ((m_addr % sz) != 0);
            op_exc = m_valid && (m_exc || mis);
            if (mem1_mem0_read)                                   win = 1;
            else if (want && !mem1_stall)                         win = 2;
            else if (m_valid && !mem1_stall && is_dc && !op_exc)  win = 3;
            else                                                  win = 0;
            exp_stall = m_valid && (mem1_stall || win == 1 || win == 2);
            exp_valid = (win == 2) || (m_valid && win != 1);
            exp_idx = (win == 1) ? 32'(mem1_mem0_addr) % 1024 :
                      (win == 2) ? 32'(faddr) % 1024 :
                      (win == 3) ? (m_addr / 4) % 1024 : 0;
            exp_vpn = (win == 3) ? m_addr / 4096 : 0;

            chk("R_stall", mem0_stall, exp_stall);
            chk("R_cam", mem0_cam_read_req, win != 0);
            chk("R_tlb", mem0_tlb_read_req, win == 3);
            chk("R_idx", 32'(mem0_cam_read_index), exp_idx);
            chk("R_vpn", 32'(mem0_tlb_read_vpn), exp_vpn);
            chk("R_ack", mem0_fe1_ack, win == 2);
            chk("R_fe1req", mem0_fe1_req, win == 2);
            chk("R_m1req", mem0_mem1_req, mem1_mem0_read || m_hold);
            chk("R_valid", mem0_valid, exp_valid);
            if (exp_valid) begin
                if (win == 2) begin
                    exp_addr = 32'(faddr) * 4;
                    chk("R_fe1_addr", mem0_addr, exp_addr);
                    chk("R_fe1_op", {mem0_exc, mem0_read, mem0_write, mem0_width, mem0_wb_reg},
                        {1'b0, 1'b1, 1'b0, 2'b10, 5'd0});
                end else begin
                    exp_cause = !op_exc ? 4'd0 : m_exc ? m_cause : m_rd ? 4'd4 : 4'd6;
                    chk("R_op_addr", mem0_addr, m_addr);
                    chk("R_op_fields", {mem0_read, mem0_write, mem0_width, mem0_wb_reg, mem0_pc},
                        {m_rd, m_wr, m_w, m_wb, m_pc});
                    chk("R_exc", mem0_exc, op_exc);
                    chk("R_cause", mem0_exc_cause, exp_cause);
                end
            end

            // reference state advance
            moves = !exp_stall;
            if (moves) begin
                m_rd = ex_read; m_wr = ex_write; m_w = ex_width; m_addr = ex_addr;
                m_exc = ex_exc; m_cause = ex_exc_cause; m_pc = ex_pc; m_wb = ex_wb_reg;
                m_wdata = ex_wdata; m_ext = ex_extend;
            end
            if (csr_kill_setpc) m_valid = 0;
            else if (moves)     m_valid = ex_valid;
            if (csr_kill_setpc || win == 2) m_pend = 0;
            else if (fe1_mem0_read && !m_pend) begin
                m_pend = 1;
                m_paddr = fe1_mem0_addr;
            end
            m_hold = mem1_mem0_read || (m_hold && mem1_stall);

            tick();
            // fetch1 drops its level request once it has been acknowledged
            if (win == 2) fe1_mem0_read = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
